// File: rtl/ucode_pkg.sv
// Microword layout, sequencing/condition encodings and FSM states shared by the
// sequencer RTL and the microcode generator.
package ucode_pkg;

  localparam int SEQ_MSB  = 15;
  localparam int SEQ_LSB  = 14;
  localparam int COND_MSB = 13;
  localparam int COND_LSB = 11;
  localparam int WAIT_BIT = 10;
  localparam int TGT_MSB  = 9;
  localparam int TGT_LSB  = 0;

  // Bit positions of the {N,V,Z,C} status vector
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  typedef enum logic [1:0] {
    SEQ_NEXT = 2'b00,
    SEQ_JUMP = 2'b01,
    SEQ_END  = 2'b10,
    SEQ_COND = 2'b11
  } seq_e;

  typedef enum logic [2:0] {
    COND_C  = 3'd0,
    COND_Z  = 3'd1,
    COND_N  = 3'd2,
    COND_V  = 3'd3,
    COND_NC = 3'd4,
    COND_NZ = 3'd5,
    COND_NN = 3'd6,
    COND_NV = 3'd7
  } cond_e;

  typedef enum logic [1:0] {
    S_WAIT_OP = 2'd0,
    S_RUN     = 2'd1,
    S_STALL   = 2'd2
  } state_e;

endpackage

// File: rtl/ucode_cond_eval.sv
// Branch condition evaluation: selects one status flag, optionally inverted.
module ucode_cond_eval
  import ucode_pkg::*;
(
  input  logic [3:0] status,
  input  logic [2:0] cond_sel,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond_sel))
      COND_C:  taken = status[FLAG_C];
      COND_Z:  taken = status[FLAG_Z];
      COND_N:  taken = status[FLAG_N];
      COND_V:  taken = status[FLAG_V];
      COND_NC: taken = !status[FLAG_C];
      COND_NZ: taken = !status[FLAG_Z];
      COND_NN: taken = !status[FLAG_N];
      COND_NV: taken = !status[FLAG_V];
    endcase
  end

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: fetches microwords from an external registered store,
// issues one per cycle, and handles jumps, conditional branches and memory stalls.
module microcode_sequencer
  import ucode_pkg::*;
#(
  parameter int  WORD_SIZE = 16,
  parameter int  ROM_SIZE  = 1024,
  localparam int AW        = $clog2(ROM_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           opcode,
  input  logic                 opcode_valid,
  output logic                 opcode_ready,
  input  logic [3:0]           status,
  input  logic                 mem_ready,
  output logic [AW-1:0]        rom_addr,
  input  logic [WORD_SIZE-1:0] rom_word,
  output logic [WORD_SIZE-1:0] ctrl_word,
  output logic                 ctrl_valid
);

  state_e               state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 fetch_vld_q, fetch_vld_d;
  logic                 squash_q, squash_d;
  logic [WORD_SIZE-1:0] hold_q, hold_d;
  logic [WORD_SIZE-1:0] last_q;
  logic [WORD_SIZE-1:0] word;
  logic                 exec;
  logic                 taken;
  seq_e                 seq;

  // A stalled word is replayed from the hold register, not the store
  assign word = (state_q == S_STALL) ? hold_q : rom_word;
  assign seq  = seq_e'(word[SEQ_MSB:SEQ_LSB]);

  ucode_cond_eval u_cond (
    .status   (status),
    .cond_sel (word[COND_MSB:COND_LSB]),
    .taken    (taken)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    fetch_vld_d = fetch_vld_q;
    squash_d    = squash_q;
    hold_d      = hold_q;
    exec        = 1'b0;
    unique case (state_q)
      S_WAIT_OP: begin
        // Squash the stale store output that arrives alongside the first fetch
        if (opcode_valid) begin
          addr_d      = AW'({opcode, 2'b00});
          fetch_vld_d = 1'b1;
          squash_d    = 1'b1;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        addr_d   = addr_q + AW'(1);
        squash_d = 1'b0;
        if (fetch_vld_q && !squash_q) begin
          if (word[WAIT_BIT] && !mem_ready) begin
            hold_d  = word;
            addr_d  = addr_q;
            state_d = S_STALL;
          end else begin
            exec = 1'b1;
          end
        end
      end
      S_STALL: begin
        // Address already holds A+1; re-issue it and drop the pending store output
        if (mem_ready) begin
          exec     = 1'b1;
          squash_d = 1'b1;
          state_d  = S_RUN;
        end
      end
      default: state_d = S_WAIT_OP;
    endcase

    if (exec) begin
      case (seq)
        SEQ_JUMP: begin
          addr_d   = AW'(word[TGT_MSB:TGT_LSB]);
          squash_d = 1'b1;
        end
        SEQ_COND: begin
          if (taken) begin
            addr_d   = AW'(word[TGT_MSB:TGT_LSB]);
            squash_d = 1'b1;
          end
        end
        SEQ_END: begin
          addr_d      = addr_q;
          fetch_vld_d = 1'b0;
          squash_d    = 1'b1;
          state_d     = S_WAIT_OP;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_WAIT_OP;
      addr_q      <= '0;
      fetch_vld_q <= 1'b0;
      squash_q    <= 1'b0;
      hold_q      <= '0;
      last_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      fetch_vld_q <= fetch_vld_d;
      squash_q    <= squash_d;
      hold_q      <= hold_d;
      if (exec) last_q <= word;
    end
  end

  assign opcode_ready = (state_q == S_WAIT_OP) && !rst;
  assign ctrl_valid   = exec && !rst;
  assign ctrl_word    = rst ? '0 : (exec ? word : last_q);
  assign rom_addr     = rst ? '0 : addr_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a program-counter level model.
module tb_microcode_sequencer;

  logic        clk;
  logic        rst;
  logic [7:0]  opcode;
  logic        opcode_valid;
  logic        opcode_ready;
  logic [3:0]  status;
  logic        mem_ready;
  logic [9:0]  rom_addr;
  logic [15:0] rom_word;
  logic [15:0] ctrl_word;
  logic        ctrl_valid;

  logic [15:0] mem [1024];
  int tests = 0;
  int fails = 0;

  microcode_sequencer #(.WORD_SIZE(16), .ROM_SIZE(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .opcode_valid (opcode_valid),
    .opcode_ready (opcode_ready),
    .status       (status),
    .mem_ready    (mem_ready),
    .rom_addr     (rom_addr),
    .rom_word     (rom_word),
    .ctrl_word    (ctrl_word),
    .ctrl_valid   (ctrl_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered microcode store
  always @(posedge clk) rom_word <= mem[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which word executes next (pc) and how many bubble cycles precede it
  typedef enum {M_IDLE, M_RUN, M_STALL} mode_t;
  mode_t       mode = M_IDLE;
  logic [9:0]  pc   = '0;
  int          dly  = 0;
  logic [15:0] held = '0;
  logic [15:0] last = '0;

  function automatic bit cond_true(input logic [2:0] sel, input logic [3:0] st);
    bit f;
    case (sel[1:0])
      2'd0: f = st[0];
      2'd1: f = st[1];
      2'd2: f = st[3];
      default: f = st[2];
    endcase
    return sel[2] ? !f : f;
  endfunction

  task automatic apply(input logic [15:0] w, input logic [9:0] fall_pc, input int fall_dly);
    if (w[15:14] == 2'b10) begin
      mode = M_IDLE;
    end else if (w[15:14] == 2'b01 || (w[15:14] == 2'b11 && cond_true(w[13:11], status))) begin
      pc = w[9:0]; dly = 1; mode = M_RUN;
    end else begin
      pc = fall_pc; dly = fall_dly; mode = M_RUN;
    end
  endtask

  always @(negedge clk) begin : model
    logic [15:0] w, ew;
    logic [9:0]  ea;
    logic        ev, er, ac;
    ev = 1'b0; er = 1'b0; ac = 1'b0; ea = '0; ew = last; w = '0;
    if (rst) begin
      ew = '0; ac = 1'b1; mode = M_IDLE; last = '0;
    end else begin
      case (mode)
        M_IDLE: begin
          er = 1'b1;
          if (opcode_valid) begin pc = {opcode, 2'b00}; dly = 1; mode = M_RUN; end
        end
        M_RUN: begin
          ac = 1'b1;
          if (dly > 0) begin
            ea = pc; dly = 0;
          end else begin
            w = mem[pc]; ea = pc + 10'd1;
            if (w[10] && !mem_ready) begin
              held = w; pc = pc + 10'd1; mode = M_STALL;
            end else begin
              ev = 1'b1; ew = w; last = w; apply(w, pc + 10'd1, 0);
            end
          end
        end
        default: begin
          ac = 1'b1; ea = pc;
          if (mem_ready) begin ev = 1'b1; ew = held; last = held; apply(held, pc, 1); end
        end
      endcase
    end
    chk("model ctrl_valid", 32'(ctrl_valid), 32'(ev));
    chk("model ctrl_word", 32'(ctrl_word), 32'(ew));
    chk("model opcode_ready", 32'(opcode_ready), 32'(er));
    if (ac) chk("model rom_addr", 32'(rom_addr), 32'(ea));
  end

  task automatic nc(); @(posedge clk); #1; endtask
  task automatic sn(); @(negedge clk); endtask

  initial begin
    rst = 1'b1; opcode = '0; opcode_valid = 1'b0; status = '0; mem_ready = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    mem[10'h2A4] = 16'h0011; mem[10'h2A5] = 16'h8022; mem[10'h040] = 16'h8077;
    mem[10'h010] = 16'h4123; mem[10'h011] = 16'h0DEF; mem[10'h123] = 16'h8055;
    mem[10'h020] = 16'hCA00; mem[10'h021] = 16'h8031; mem[10'h200] = 16'h8042;
    mem[10'h030] = 16'h0405; mem[10'h031] = 16'h8066;
    mem[10'h3FC] = 16'h0001; mem[10'h3FD] = 16'h0002; mem[10'h3FE] = 16'h0003;
    mem[10'h3FF] = 16'h0004; mem[10'h000] = 16'h8099;

    nc(); nc(); sn();
    chk("rst rom_addr", 32'(rom_addr), 32'h0);
    chk("rst ctrl_valid", 32'(ctrl_valid), 32'h0);
    chk("rst ctrl_word", 32'(ctrl_word), 32'h0);
    chk("rst opcode_ready", 32'(opcode_ready), 32'h0);

    // Opcode A9, two-word program, END overlapping a new opcode
    nc(); rst = 1'b0; opcode = 8'hA9; opcode_valid = 1'b1; sn();
    chk("a9 ready after rst", 32'(opcode_ready), 32'h1);
    nc(); opcode_valid = 1'b0; sn();
    chk("a9 rom_addr", 32'(rom_addr), 32'h2A4);
    chk("a9 first bubble", 32'(ctrl_valid), 32'h0);
    nc(); sn();
    chk("a9 word0", 32'(ctrl_word), 32'h0011);
    chk("a9 valid0", 32'(ctrl_valid), 32'h1);
    chk("a9 spec addr", 32'(rom_addr), 32'h2A5);
    nc(); opcode = 8'h10; opcode_valid = 1'b1; sn();
    chk("a9 word1", 32'(ctrl_word), 32'h8022);
    chk("a9 valid1", 32'(ctrl_valid), 32'h1);
    chk("end ready low", 32'(opcode_ready), 32'h0);
    nc(); sn();
    chk("after end ready", 32'(opcode_ready), 32'h1);
    chk("after end word held", 32'(ctrl_word), 32'h8022);
    nc(); opcode_valid = 1'b0; sn();
    chk("op10 rom_addr", 32'(rom_addr), 32'h040);
    nc(); sn();
    chk("op10 word", 32'(ctrl_word), 32'h8077);
    nc(); sn();

    // JUMP at 0x010 to 0x123
    nc(); opcode = 8'h04; opcode_valid = 1'b1; sn();
    nc(); opcode_valid = 1'b0; sn();
    nc(); sn();
    chk("jump word", 32'(ctrl_word), 32'h4123);
    nc(); sn();
    chk("jump bubble", 32'(ctrl_valid), 32'h0);
    chk("jump bubble word", 32'(ctrl_word), 32'h4123);
    nc(); sn();
    chk("jump target word", 32'(ctrl_word), 32'h8055);
    chk("jump target valid", 32'(ctrl_valid), 32'h1);
    nc(); sn();

    // COND on Z: taken with Z=1
    nc(); opcode = 8'h08; opcode_valid = 1'b1; status = 4'b0010; sn();
    nc(); opcode_valid = 1'b0; sn();
    nc(); sn();
    chk("cond word", 32'(ctrl_word), 32'hCA00);
    nc(); sn();
    chk("cond taken bubble", 32'(ctrl_valid), 32'h0);
    nc(); sn();
    chk("cond taken target", 32'(ctrl_word), 32'h8042);
    nc(); sn();

    // COND on Z: not taken with Z=0, no bubble
    nc(); opcode = 8'h08; opcode_valid = 1'b1; status = 4'b0000; sn();
    nc(); opcode_valid = 1'b0; sn();
    nc(); sn();
    nc(); sn();
    chk("cond fall valid", 32'(ctrl_valid), 32'h1);
    chk("cond fall word", 32'(ctrl_word), 32'h8031);
    nc(); sn();

    // Wait word with mem_ready low for three cycles
    nc(); opcode = 8'h0C; opcode_valid = 1'b1; mem_ready = 1'b0; sn();
    nc(); opcode_valid = 1'b0; sn();
    for (int k = 0; k < 3; k++) begin
      nc(); sn();
      chk("stall no valid", 32'(ctrl_valid), 32'h0);
    end
    nc(); mem_ready = 1'b1; sn();
    chk("stall release word", 32'(ctrl_word), 32'h0405);
    chk("stall release valid", 32'(ctrl_valid), 32'h1);
    nc(); sn();
    chk("stall exit bubble", 32'(ctrl_valid), 32'h0);
    nc(); sn();
    chk("stall next word", 32'(ctrl_word), 32'h8066);
    nc(); sn();

    // Reset pulse during STALL
    nc(); opcode = 8'h0C; opcode_valid = 1'b1; mem_ready = 1'b0; sn();
    nc(); opcode_valid = 1'b0; sn();
    nc(); sn();
    nc(); rst = 1'b1; sn();
    chk("stall rst valid", 32'(ctrl_valid), 32'h0);
    nc(); rst = 1'b0; mem_ready = 1'b1; sn();
    chk("post rst rom_addr", 32'(rom_addr), 32'h0);
    chk("post rst valid", 32'(ctrl_valid), 32'h0);
    chk("post rst ready", 32'(opcode_ready), 32'h1);
    nc(); sn();
    chk("post rst no pulse", 32'(ctrl_valid), 32'h0);

    // Address wrap 0x3FF -> 0x000
    nc(); opcode = 8'hFF; opcode_valid = 1'b1; sn();
    nc(); opcode_valid = 1'b0; sn();
    chk("wrap start addr", 32'(rom_addr), 32'h3FC);
    nc(); sn(); nc(); sn(); nc(); sn();
    nc(); sn();
    chk("wrap word 3ff", 32'(ctrl_word), 32'h0004);
    chk("wrap rom_addr", 32'(rom_addr), 32'h000);
    nc(); sn();
    chk("wrap word 000", 32'(ctrl_word), 32'h8099);
    nc(); sn();

    // Randomized traffic
    nc(); rst = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    for (int n = 0; n < 4000; n++) begin
      nc();
      rst          = ($urandom_range(0, 63) == 0);
      opcode       = 8'($urandom);
      opcode_valid = ($urandom_range(0, 1) == 1);
      status       = 4'($urandom);
      mem_ready    = ($urandom_range(0, 3) != 0);
    end
    nc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/microcode_sequencer.md
MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, microword width.
REQ-002 SHALL have parameter ROM_SIZE, default 1024, microcode store depth; address width AW = clog2(ROM_SIZE) = 10.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port opcode, input, 8, fetched 6502 opcode.
REQ-006 SHALL have port opcode_valid, input, 1, opcode present.
REQ-007 SHALL have port opcode_ready, output, 1, sequencer accepts opcode this cycle.
REQ-008 SHALL have port status, input, 4, flags {N,V,Z,C}.
REQ-009 SHALL have port mem_ready, input, 1, datapath memory access complete.
REQ-010 SHALL have port rom_addr, output, AW, address to the registered microcode store.
REQ-011 SHALL have port rom_word, input, WORD_SIZE, store output, valid one cycle after rom_addr.
REQ-012 SHALL have port ctrl_word, output, WORD_SIZE, microword issued to datapath.
REQ-013 SHALL have port ctrl_valid, output, 1, ctrl_word executes this cycle.

Function
REQ-014 Microword fields SHALL be: [15:14] seq (00 NEXT, 01 JUMP, 10 END, 11 COND), [13:11] cond_sel, [10] wait, [9:0] target.
REQ-015 cond_sel SHALL map 0..7 to C, Z, N, V, !C, !Z, !N, !V.
REQ-016 The FSM SHALL have the states WAIT_OP, RUN and STALL.
REQ-017 In WAIT_OP, opcode_ready SHALL be 1.
REQ-018 In WAIT_OP, on opcode_valid, rom_addr SHALL load {opcode,2'b00}, a fetch-valid bit SHALL set and the FSM SHALL go to RUN.
REQ-019 In RUN, each cycle with the fetch-valid bit set and squash clear, rom_word is the current word W at address A.
REQ-020 In RUN, rom_addr SHALL advance to A+1 speculatively one cycle after issuing A.
REQ-021 W executing SHALL mean ctrl_word=W and ctrl_valid=1 in the same cycle; otherwise ctrl_valid SHALL be 0 and ctrl_word SHALL hold its last value.
REQ-022 NEXT SHALL continue the sequence: rom_addr increments, giving 1 word per cycle throughput.
REQ-023 JUMP, and COND with a true condition, SHALL load target into rom_addr and set squash, so that the speculative word is discarded (one bubble).
REQ-024 COND with a false condition SHALL behave as NEXT.
REQ-025 END SHALL execute W, squash the speculative word, and move the FSM to WAIT_OP.
REQ-026 With wait=1 and mem_ready=0, the sequencer SHALL capture W in a hold register, set ctrl_valid=0, and go to STALL.
REQ-027 STALL SHALL hold until mem_ready=1; it SHALL then execute the held word and apply its seq field.
REQ-028 On leaving STALL, NEXT SHALL re-issue A+1 (one bubble).
REQ-029 With wait=1 and mem_ready=1 in the same cycle, W SHALL execute without stall.
REQ-030 rom_addr increment SHALL wrap from ROM_SIZE-1 to 0 modulo 2^AW.
REQ-031 status SHALL be sampled in the cycle W executes, not when W was fetched.
REQ-032 opcode_valid SHALL be ignored outside WAIT_OP.
REQ-033 An END followed by an opcode_valid in the next cycle SHALL be accepted, giving a minimum 1-cycle gap.

Reset
REQ-034 While rst=1, the FSM SHALL be in WAIT_OP.
REQ-035 While rst=1, rom_addr SHALL be 0, ctrl_word 0, ctrl_valid 0 and opcode_ready 0.
REQ-036 While rst=1, the fetch-valid bit, squash bit and hold register SHALL be cleared.
REQ-037 rst asserted mid-RUN or mid-STALL SHALL abort the instruction with no ctrl_valid pulse in the cycle following the reset edge.
REQ-038 opcode_ready SHALL rise in the first cycle after rst deasserts.

Structure
REQ-039 Shared package ucode_pkg SHALL hold the seq encodings, field bit positions, cond_sel codes and FSM state encoding, shared with the microcode generator.
REQ-040 Condition evaluation SHALL live in sub-module ucode_cond_eval (status, cond_sel -> taken).
REQ-041 The microcode store SHALL be instantiated outside this block.

Verification
REQ-042 Reset then opcode=0xA9 with opcode_valid: SHALL give rom_addr=0x2A4; SHALL then issue words 0x2A4, 0x2A5 on consecutive cycles with ctrl_valid=1 for 2 cycles.
REQ-043 Word 0x4123 (JUMP to 0x123) at addr 0x010: next executed word from 0x123, with exactly 1 ctrl_valid=0 bubble and word 0x011 never executed.
REQ-044 COND cond_sel=1 (Z): with status=4'b0010 (Z=1), the branch SHALL be taken; with status=0, the fall-through SHALL execute with no bubble.
REQ-045 Word with wait=1, mem_ready low 3 cycles: ctrl_valid=0 for 3 cycles, then the held word executes once on the mem_ready=1 cycle.
REQ-046 END then opcode_valid asserted in the same cycle: opcode ignored; opcode_valid held on the next cycle is accepted with opcode_ready=1.
REQ-047 rst pulsed during STALL: rom_addr=0, ctrl_valid=0 and WAIT_OP on the next cycle; a NEXT at 0x3FF SHALL fetch 0x000.
